// File: rtl/fan_pkg.sv
// Shared encodings for the fan controller: gears, fuel-gauge modes, level range and BCD form.
package fan_pkg;

  localparam int unsigned LEVEL_W = 7;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd100;

  localparam logic [1:0] GEAR_OFF  = 2'b00;
  localparam logic [1:0] GEAR_LOW  = 2'b01;
  localparam logic [1:0] GEAR_MID  = 2'b10;
  localparam logic [1:0] GEAR_HIGH = 2'b11;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_DRAIN  = 2'd1;
  localparam logic [1:0] MODE_CHARGE = 2'd2;
  localparam logic [1:0] MODE_FULL   = 2'd3;

  typedef struct packed {
    logic       hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Elaboration-time only; the running BCD value is maintained incrementally.
  function automatic bcd_t level_to_bcd(input int unsigned v);
    bcd_t b;
    b.hund = (v >= 100);
    b.tens = 4'((v % 100) / 10);
    b.ones = 4'(v % 10);
    return b;
  endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// Three-digit BCD counter (0..100) with load, +1 and -1; load has priority over inc over dec.
module bcd_updown_counter
  import fan_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  logic       load_hund,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       inc,
  input  logic       dec,
  output logic       hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic       hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      hund_d = load_hund;
      tens_d = load_tens;
      ones_d = load_ones;
    end else if (inc) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          hund_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec) begin
      if (hund_q) begin
        hund_d = 1'b0;
        tens_d = 4'd9;
        ones_d = 4'd9;
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    hund_q <= hund_d;
    tens_q <= tens_d;
    ones_q <= ones_d;
  end

  assign hund = hund_q;
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/battery_fuel_gauge.sv
// Battery state-of-charge engine: mode FSM, step prescaler, level/BCD tracking and status flags.
module battery_fuel_gauge
  import fan_pkg::*;
#(
  parameter int unsigned INIT_LEVEL    = 100,
  parameter int unsigned PER_LOW       = 100,
  parameter int unsigned PER_MID       = 50,
  parameter int unsigned PER_HIGH      = 25,
  parameter int unsigned PER_CHG       = 20,
  parameter int unsigned LOW_THRESH    = 20,
  parameter int unsigned EMPTY_RELEASE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] fan_state,
  input  logic       charging,
  output logic [6:0] level,
  output logic       bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       battery_empty,
  output logic       battery_low,
  output logic       battery_full
);

  localparam int unsigned PER_MAX_A = (PER_LOW > PER_MID) ? PER_LOW : PER_MID;
  localparam int unsigned PER_MAX_B = (PER_HIGH > PER_CHG) ? PER_HIGH : PER_CHG;
  localparam int unsigned PER_MAX   = (PER_MAX_A > PER_MAX_B) ? PER_MAX_A : PER_MAX_B;
  localparam int unsigned CNT_W     = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

  localparam logic [CNT_W-1:0] LOW_M1  = CNT_W'(PER_LOW - 1);
  localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(PER_MID - 1);
  localparam logic [CNT_W-1:0] HIGH_M1 = CNT_W'(PER_HIGH - 1);
  localparam logic [CNT_W-1:0] CHG_M1  = CNT_W'(PER_CHG - 1);

  localparam logic [LEVEL_W-1:0] INIT_LVL    = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] LOW_LVL     = LEVEL_W'(LOW_THRESH);
  localparam logic [LEVEL_W-1:0] RELEASE_LVL = LEVEL_W'(EMPTY_RELEASE);
  localparam bcd_t               INIT_BCD    = level_to_bcd(INIT_LEVEL);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         fan_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_m1;
  logic               empty_q, empty_d;
  logic               step_up, step_dn;
  logic               restart;

  // Charging wins over draining; a full battery on charge parks in FULL.
  always_comb begin
    if (charging && (level_q < LEVEL_MAX)) begin
      mode_d = MODE_CHARGE;
    end else if (charging) begin
      mode_d = MODE_FULL;
    end else if ((fan_state != GEAR_OFF) && (level_q != '0)) begin
      mode_d = MODE_DRAIN;
    end else begin
      mode_d = MODE_HOLD;
    end
  end

  always_comb begin
    period_m1 = CHG_M1;
    if (mode_d == MODE_DRAIN) begin
      unique case (fan_state)
        GEAR_LOW:  period_m1 = LOW_M1;
        GEAR_MID:  period_m1 = MID_M1;
        GEAR_HIGH: period_m1 = HIGH_M1;
        default:   period_m1 = CHG_M1;
      endcase
    end
  end

  assign restart = (mode_d != mode_q) || (fan_state != fan_q) ||
                   (mode_d == MODE_HOLD) || (mode_d == MODE_FULL);

  always_comb begin
    cnt_d   = cnt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (tick) begin
      if (restart) begin
        cnt_d = '0;
      end else if (cnt_q == period_m1) begin
        cnt_d   = '0;
        step_up = (mode_d == MODE_CHARGE);
        step_dn = (mode_d == MODE_DRAIN);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (step_up) begin
      level_d = level_q + 1'b1;
    end else if (step_dn) begin
      level_d = level_q - 1'b1;
    end
  end

  // Empty latches at 0 and only releases once charging has climbed back to the release level.
  always_comb begin
    empty_d = empty_q;
    if (step_dn && (level_d == '0)) begin
      empty_d = 1'b1;
    end else if (step_up && (level_d == RELEASE_LVL)) begin
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= INIT_LVL;
      mode_q  <= MODE_HOLD;
      fan_q   <= GEAR_OFF;
      cnt_q   <= '0;
      empty_q <= (INIT_LEVEL == 0);
    end else if (tick) begin
      level_q <= level_d;
      mode_q  <= mode_d;
      fan_q   <= fan_state;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  bcd_updown_counter u_bcd (
    .clk       (clk),
    .load      (reset),
    .load_hund (INIT_BCD.hund),
    .load_tens (INIT_BCD.tens),
    .load_ones (INIT_BCD.ones),
    .inc       (step_up),
    .dec       (step_dn),
    .hund      (bcd_hund),
    .tens      (bcd_tens),
    .ones      (bcd_ones)
  );

  assign level         = level_q;
  assign battery_empty = empty_q;
  assign battery_low   = (level_q <= LOW_LVL);
  assign battery_full  = (level_q == LEVEL_MAX);

  // The mode FSM must never request a step past either bound.
  assert property (@(posedge clk) disable iff (reset)
    !(step_up && (level_q == LEVEL_MAX)) && !(step_dn && (level_q == '0)));

endmodule

// File: tb/tb_battery_fuel_gauge.sv
// Directed bench for battery_fuel_gauge with default parameters (INIT_LEVEL = 100).
module tb_battery_fuel_gauge;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] fan_state;
  logic       charging;
  logic [6:0] level;
  logic       bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       battery_empty;
  logic       battery_low;
  logic       battery_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  battery_fuel_gauge dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .fan_state     (fan_state),
    .charging      (charging),
    .level         (level),
    .bcd_hund      (bcd_hund),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .battery_empty (battery_empty),
    .battery_low   (battery_low),
    .battery_full  (battery_full)
  );

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic [6:0] target, input int budget);
    int n = 0;
    while (level !== target && n < budget) begin
      wait_edges(1);
      n++;
    end
    checks++;
    if (level !== target) begin
      failures++;
      $display("FAIL wait_level: level=%0d required=%0d within %0d cycles", level, target, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b1; fan_state = 2'b00; charging = 1'b0;
    wait_edges(2);
    checks++;
    if ({level, bcd_hund, bcd_tens, bcd_ones} !== {7'd100, 1'b1, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_level: level=%0d bcd=%0d/%0d/%0d required 100 1/0/0",
               level, bcd_hund, bcd_tens, bcd_ones);
    end
    checks++;
    if ({battery_empty, battery_low, battery_full} !== 3'b001) begin
      failures++;
      $display("FAIL reset_flags: e/l/f=%b%b%b required 001",
               battery_empty, battery_low, battery_full);
    end
    reset = 1'b0;
    wait_edges(50);
    checks++;
    if (level !== 7'd100) begin
      failures++;
      $display("FAIL hold_fan_off: level=%0d required 100", level);
    end
  endtask

  task automatic test_drain_high();
    fan_state = 2'b11;
    wait_edges(25);
    checks++;
    if ({level, battery_full} !== {7'd100, 1'b1}) begin
      failures++;
      $display("FAIL drain_pre_step: level=%0d full=%b required 100 1", level, battery_full);
    end
    wait_edges(1);
    checks++;
    if ({level, bcd_hund, bcd_tens, bcd_ones, battery_full} !==
        {7'd99, 1'b0, 4'd9, 4'd9, 1'b0}) begin
      failures++;
      $display("FAIL drain_first_step: level=%0d bcd=%0d/%0d/%0d full=%b required 99 0/9/9 0",
               level, bcd_hund, bcd_tens, bcd_ones, battery_full);
    end
    wait_edges(24);
    checks++;
    if (level !== 7'd99) begin
      failures++;
      $display("FAIL drain_mid_period: level=%0d required 99", level);
    end
    wait_edges(1);
    checks++;
    if ({level, bcd_hund, bcd_tens, bcd_ones} !== {7'd98, 1'b0, 4'd9, 4'd8}) begin
      failures++;
      $display("FAIL drain_second_step: level=%0d bcd=%0d/%0d/%0d required 98 0/9/8",
               level, bcd_hund, bcd_tens, bcd_ones);
    end
  endtask

  task automatic test_low_and_gear_switch();
    wait_level(7'd21, 2500);
    fan_state = 2'b01;
    wait_edges(100);
    checks++;
    if ({level, battery_low} !== {7'd21, 1'b0}) begin
      failures++;
      $display("FAIL low_pre_step: level=%0d low=%b required 21 0", level, battery_low);
    end
    wait_edges(1);
    checks++;
    if ({level, battery_low, bcd_tens, bcd_ones} !== {7'd20, 1'b1, 4'd2, 4'd0}) begin
      failures++;
      $display("FAIL low_step: level=%0d low=%b bcd=%0d%0d required 20 1 20",
               level, battery_low, bcd_tens, bcd_ones);
    end
    wait_edges(30);
    fan_state = 2'b10;
    wait_edges(21);
    checks++;
    if (level !== 7'd20) begin
      failures++;
      $display("FAIL gear_switch_no_carry: level=%0d required 20", level);
    end
    wait_edges(29);
    checks++;
    if (level !== 7'd20) begin
      failures++;
      $display("FAIL gear_switch_early: level=%0d required 20", level);
    end
    wait_edges(1);
    checks++;
    if ({level, bcd_tens, bcd_ones} !== {7'd19, 4'd1, 4'd9}) begin
      failures++;
      $display("FAIL gear_switch_step: level=%0d bcd=%0d%0d required 19 19",
               level, bcd_tens, bcd_ones);
    end
  endtask

  task automatic test_empty_charge();
    fan_state = 2'b11;
    wait_level(7'd0, 1000);
    checks++;
    if ({battery_empty, battery_low, battery_full, bcd_hund, bcd_tens, bcd_ones} !==
        {3'b110, 1'b0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL empty_set: e/l/f=%b%b%b bcd=%0d/%0d/%0d required 110 0/0/0",
               battery_empty, battery_low, battery_full, bcd_hund, bcd_tens, bcd_ones);
    end
    wait_edges(60);
    checks++;
    if ({level, battery_empty} !== {7'd0, 1'b1}) begin
      failures++;
      $display("FAIL empty_hold: level=%0d empty=%b required 0 1", level, battery_empty);
    end
    charging = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      wait_edges((t == 1) ? 20 : 19);
      checks++;
      if (level !== 7'(t - 1)) begin
        failures++;
        $display("FAIL charge_pre_step: level=%0d required %0d", level, t - 1);
      end
      wait_edges(1);
      checks++;
      if ({level, battery_empty} !== {7'(t), (t < 5)}) begin
        failures++;
        $display("FAIL charge_empty_hyst: level=%0d empty=%b required %0d %0d",
                 level, battery_empty, t, (t < 5));
      end
    end
  endtask

  task automatic test_full();
    wait_level(7'd99, 2500);
    wait_edges(19);
    checks++;
    if ({level, battery_full} !== {7'd99, 1'b0}) begin
      failures++;
      $display("FAIL full_pre_step: level=%0d full=%b required 99 0", level, battery_full);
    end
    wait_edges(1);
    checks++;
    if ({level, bcd_hund, bcd_tens, bcd_ones, battery_full, battery_low} !==
        {7'd100, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_step: level=%0d bcd=%0d/%0d/%0d full=%b low=%b required 100 1/0/0 1 0",
               level, bcd_hund, bcd_tens, bcd_ones, battery_full, battery_low);
    end
    wait_edges(200);
    checks++;
    if ({level, battery_full} !== {7'd100, 1'b1}) begin
      failures++;
      $display("FAIL full_hold: level=%0d full=%b required 100 1", level, battery_full);
    end
  endtask

  task automatic test_tick_gated();
    for (int c = 0; c <= 150; c++) begin
      tick = (c % 3 == 0);
      if (c == 0) charging = 1'b0;
      wait_edges(1);
      if (c == 74 || c == 75 || c == 149 || c == 150) begin
        checks++;
        if (level !== ((c < 75) ? 7'd100 : (c < 150) ? 7'd99 : 7'd98)) begin
          failures++;
          $display("FAIL tick_gated: cycle=%0d level=%0d", c, level);
        end
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    wait_level(7'd37, 2000);
    wait_edges(17);
    reset = 1'b1;
    wait_edges(1);
    checks++;
    if ({level, bcd_hund, bcd_tens, bcd_ones} !== {7'd100, 1'b1, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_mid_level: level=%0d bcd=%0d/%0d/%0d required 100 1/0/0",
               level, bcd_hund, bcd_tens, bcd_ones);
    end
    checks++;
    if ({battery_empty, battery_low, battery_full} !== 3'b001) begin
      failures++;
      $display("FAIL reset_mid_flags: e/l/f=%b%b%b required 001",
               battery_empty, battery_low, battery_full);
    end
    reset = 1'b0;
    wait_edges(25);
    checks++;
    if (level !== 7'd100) begin
      failures++;
      $display("FAIL reset_mid_pending: level=%0d required 100", level);
    end
    wait_edges(1);
    checks++;
    if (level !== 7'd99) begin
      failures++;
      $display("FAIL reset_mid_restep: level=%0d required 99", level);
    end
  endtask

  initial begin
    test_reset();
    test_drain_high();
    test_low_and_gear_switch();
    test_empty_charge();
    test_full();
    test_tick_gated();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
